fifo_wr_arbiter: RTL and testbench



---
 rtl/fifo_wr_arbiter.sv | 110 +++++++++++
 tb/tb_fifo_wr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ producers.
// Each grant is capped at MAX_BURST accepted writes, followed by one IDLE cycle.

module fifo_wr_arb_lane #(
    parameter int FIFO_WIDTH = 2
) (
    input  logic                  wr_en,
    input  logic                  is_owner,
    input  logic [FIFO_WIDTH-1:0] data,
    output logic                  ack,
    output logic [FIFO_WIDTH-1:0] data_gated
);
    assign ack        = wr_en & is_owner;
    assign data_gated = ack ? data : '0;
endmodule

module fifo_wr_arbiter #(
    parameter int N_REQ      = 4,
    parameter int FIFO_WIDTH = 2,
    parameter int MAX_BURST  = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*FIFO_WIDTH-1:0] req_data,
    input  logic                        fifo_full,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            ack,
    output logic                        fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]       fifo_wr_data
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t                             state;
    logic [IW-1:0]                      owner, ptr, ptr_nxt;
    logic [IW-1:0]                      pick, pick_lo, pick_hi;
    logic                               pick_vld, hi_vld;
    logic [CW-1:0]                      cnt;
    logic [N_REQ-1:0][FIFO_WIDTH-1:0]   data_arr, data_gated;

    assign data_arr = req_data;

    // Round-robin scan: lowest requester at or above ptr, else wrap to lowest overall.
    always_comb begin
        pick_lo = '0;
        pick_hi = '0;
        hi_vld  = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) pick_lo = IW'(i);
            if (req[i] && (IW'(i) >= ptr)) begin
                pick_hi = IW'(i);
                hi_vld  = 1'b1;
            end
        end
        pick     = hi_vld ? pick_hi : pick_lo;
        pick_vld = |req;
    end

    assign ptr_nxt    = (owner == IW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign fifo_wr_en = (state == GRANT) && req[owner] && !fifo_full && !reset;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        fifo_wr_arb_lane #(.FIFO_WIDTH(FIFO_WIDTH)) u_lane (
            .wr_en      (fifo_wr_en),
            .is_owner   (owner == IW'(i)),
            .data       (data_arr[i]),
            .ack        (ack[i]),
            .data_gated (data_gated[i])
        );
    end

    always_comb begin
        fifo_wr_data = '0;
        for (int i = 0; i < N_REQ; i++) fifo_wr_data |= data_gated[i];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= '0;
            ptr   <= '0;
            cnt   <= '0;
            owner <= '0;
        end else begin
            case (state)
                IDLE: if (pick_vld) begin
                    owner <= pick;
                    gnt   <= N_REQ'(1) << pick;
                    cnt   <= '0;
                    state <= GRANT;
                end
                GRANT: begin
                    // A full FIFO with req held leaves everything untouched.
                    if (!req[owner] || (fifo_wr_en && cnt == CW'(MAX_BURST - 1))) begin
                        state <= IDLE;
                        gnt   <= '0;
                        ptr   <= ptr_nxt;
                        cnt   <= '0;
                    end else if (fifo_wr_en) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a behavioural depth-4 FIFO and a write scoreboard.
module tb_fifo_wr_arbiter;
    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [3:0]       req = '0;
    logic [3:0][1:0]  rdata = '0;
    logic [7:0]       req_data;
    logic             fifo_full = 1'b0;
    logic [3:0]       gnt, ack;
    logic             fifo_wr_en;
    logic [1:0]       fifo_wr_data;
    logic             rd_en = 1'b0;
    logic             pf = 1'b0;

    int n_err = 0;
    int n_chk = 0;
    int base;
    int cnt_before;
    logic [3:0] eg;
    logic [1:0] exp_q[$];
    logic [1:0] fifo_q[$];
    logic [1:0] rd_log[$];
    bit do_rd, do_wr;

    assign req_data = rdata;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.N_REQ(4), .FIFO_WIDTH(2), .MAX_BURST(2)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_data     (req_data),
        .fifo_full    (fifo_full),
        .gnt          (gnt),
        .ack          (ack),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_wr_data (fifo_wr_data)
    );

    // Behavioural FIFO, depth 4; pf fills it to the brim in one cycle.
    always @(posedge clk) begin : fifo_model
        if (pf) begin
            for (int k = fifo_q.size(); k < 4; k++) fifo_q.push_back(2'(k));
        end else begin
            do_rd = rd_en && (fifo_q.size() > 0);
            do_wr = fifo_wr_en && (fifo_q.size() < 4);
            if (do_rd) rd_log.push_back(fifo_q.pop_front());
            if (do_wr) fifo_q.push_back(fifo_wr_data);
        end
        fifo_full <= (fifo_q.size() == 4);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Sample one cycle at negedge; ack seen here is the write at the coming edge.
    task automatic chk(input string tag, input logic [3:0] g, input logic [3:0] a);
        @(negedge clk);
        check({tag, " gnt"}, 32'(gnt), 32'(g));
        check({tag, " ack"}, 32'(ack), 32'(a));
        check({tag, " wr_en"}, 32'(fifo_wr_en), 32'(|a));
        if (fifo_wr_en) begin
            check({tag, " sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) check({tag, " wr_data"}, 32'(fifo_wr_data), 32'(exp_q.pop_front()));
        end else begin
            check({tag, " wr_data_zero"}, 32'(fifo_wr_data), 32'd0);
        end
    endtask

    task automatic sb_push(input logic [1:0] d, input int n);
        for (int k = 0; k < n; k++) exp_q.push_back(d);
    endtask

    task automatic do_reset();
        nxt(); reset = 1'b1; chk("rst_cyc", 4'b0000, 4'b0000);
        nxt(); reset = 1'b0; chk("rst_done", 4'b0000, 4'b0000);
    endtask

    initial begin
        logic [1:0] fr_exp [10];

        // Reset held two cycles with every producer requesting
        reset = 1'b1; req = 4'b1111; rdata = {2'd3, 2'd2, 2'd1, 2'd0};
        nxt(); chk("rst0", 4'b0000, 4'b0000);
        nxt(); reset = 1'b0; chk("rst1", 4'b0000, 4'b0000);
        nxt(); req = 4'b0000; chk("rst_first_gnt", 4'b0001, 4'b0000);
        nxt(); chk("rst_rel", 4'b0000, 4'b0000);

        // Single producer: two-write burst, one idle cycle, wrap-around re-grant
        nxt(); req = 4'b0100; rdata[2] = 2'b10; sb_push(2'b10, 3); chk("sp_req", 4'b0000, 4'b0000);
        nxt(); chk("sp_w1", 4'b0100, 4'b0100);
        nxt(); chk("sp_w2", 4'b0100, 4'b0100);
        nxt(); chk("sp_idle", 4'b0000, 4'b0000);
        nxt(); chk("sp_regrant", 4'b0100, 4'b0100);
        nxt(); req = 4'b0000; chk("sp_drop", 4'b0100, 4'b0000);
        nxt(); chk("sp_rel", 4'b0000, 4'b0000);
        check("sp_fifo_cnt", 32'(fifo_q.size()), 32'd3);
        for (int k = 0; k < 3 && k < fifo_q.size(); k++) check("sp_fifo_data", 32'(fifo_q[k]), 32'(2'b10));
        for (int k = 0; k < 4; k++) begin
            nxt(); rd_en = 1'b1; chk("sp_drain", 4'b0000, 4'b0000);
        end
        check("sp_drained", 32'(fifo_q.size()), 32'd0);

        // Fairness: all four requesting, grant order 0,1,2,3,0 with 2 writes each
        do_reset();
        base = rd_log.size();
        nxt(); req = 4'b1111; rdata = {2'd0, 2'd3, 2'd2, 2'd1};
        for (int g = 0; g < 5; g++) begin
            fr_exp[2*g]   = 2'((g % 4) + 1);
            fr_exp[2*g+1] = 2'((g % 4) + 1);
            sb_push(2'((g % 4) + 1), 2);
        end
        chk("fr_req", 4'b0000, 4'b0000);
        for (int g = 0; g < 5; g++) begin
            eg = 4'b0001 << (g % 4);
            nxt(); chk("fr_w1", eg, eg);
            nxt(); chk("fr_w2", eg, eg);
            nxt(); if (g == 4) req = 4'b0000; chk("fr_idle", 4'b0000, 4'b0000);
        end
        nxt(); chk("fr_end0", 4'b0000, 4'b0000);
        nxt(); chk("fr_end1", 4'b0000, 4'b0000);
        check("fr_rd_cnt", 32'(rd_log.size() - base), 32'd10);
        for (int k = 0; k < 10 && (base + k) < rd_log.size(); k++)
            check("fr_rd_order", 32'(rd_log[base + k]), 32'(fr_exp[k]));

        // Full stall: grant held, no ack, burst count preserved across stalls
        rd_en = 1'b0;
        do_reset();
        nxt(); pf = 1'b1; chk("fs_fill", 4'b0000, 4'b0000);
        nxt(); pf = 1'b0; req = 4'b0010; rdata[1] = 2'b01; sb_push(2'b01, 2); chk("fs_req", 4'b0000, 4'b0000);
        nxt(); chk("fs_stall0", 4'b0010, 4'b0000);
        nxt(); chk("fs_stall1", 4'b0010, 4'b0000);
        nxt(); rd_en = 1'b1; chk("fs_rd", 4'b0010, 4'b0000);
        nxt(); rd_en = 1'b0; chk("fs_unfull", 4'b0010, 4'b0010);
        nxt(); chk("fs_full2", 4'b0010, 4'b0000);
        nxt(); rd_en = 1'b1; chk("fs_rd2", 4'b0010, 4'b0000);
        nxt(); rd_en = 1'b0; chk("fs_unfull2", 4'b0010, 4'b0010);
        nxt(); req = 4'b0000; chk("fs_rel", 4'b0000, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            nxt(); rd_en = 1'b1; chk("fs_drain", 4'b0000, 4'b0000);
        end

        // Early drop by producer 3, then ptr wraps to 0
        do_reset();
        nxt(); req = 4'b1000; rdata[3] = 2'b11; sb_push(2'b11, 1); chk("ed_req", 4'b0000, 4'b0000);
        nxt(); chk("ed_g3", 4'b1000, 4'b1000);
        nxt(); req = 4'b0001; rdata[0] = 2'b01; chk("ed_drop", 4'b1000, 4'b0000);
        nxt(); req = 4'b1001; sb_push(2'b01, 1); chk("ed_rel", 4'b0000, 4'b0000);
        nxt(); chk("ed_g0", 4'b0001, 4'b0001);
        nxt(); req = 4'b0000; chk("ed_g0_drop", 4'b0001, 4'b0000);
        nxt(); chk("ed_rel2", 4'b0000, 4'b0000);

        // Reset mid-burst: no write in the reset cycle, ptr back to 0
        nxt(); rd_en = 1'b0; req = 4'b1010; rdata[1] = 2'b10; rdata[3] = 2'b11; chk("rb_req", 4'b0000, 4'b0000);
        nxt(); reset = 1'b1; chk("rb_rst_cycle", 4'b0010, 4'b0000);
        cnt_before = fifo_q.size();
        nxt(); reset = 1'b0; req = 4'b1001; rdata[0] = 2'b01; chk("rb_after", 4'b0000, 4'b0000);
        check("rb_fifo_cnt", 32'(fifo_q.size()), 32'(cnt_before));
        nxt(); req = 4'b0000; chk("rb_ptr0", 4'b0001, 4'b0000);
        nxt(); chk("rb_end", 4'b0000, 4'b0000);

        check("sb_all_written", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
